// File: rtl/pot_pkg.sv
// Shared types and constants for the paddle pot sequencer.
package pot_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StDischarge = 2'd1,
        StCharge    = 2'd2
    } pot_state_e;

    localparam int unsigned CntWidth  = 10;
    localparam logic [7:0]  PotAbsent = 8'hFF;

    // Paddle value for chooser slot idx, or the absent value when unassigned.
    function automatic logic [7:0] pick_pot(input logic [3:0][7:0] pd,
                                            input logic [3:0]      present,
                                            input logic [1:0]      idx);
        return present[idx] ? pd[idx] : PotAbsent;
    endfunction

endpackage

// File: rtl/pot_channel.sv
// One pot channel: holds the period's latched value and emulates the comparator.
module pot_channel
    import pot_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                latch_i,
    input  logic [7:0]          latch_val_i,
    input  logic                chg_next_i,
    input  logic [CntWidth-1:0] cnt_next_i,
    output logic [7:0]          value_o,
    output logic                cmp_o
);

    logic [7:0] value_q, value_d;
    logic       cmp_q, cmp_d;

    // Compare against next-state values so the registered flag lines up with the counter.
    always_comb begin
        value_d = latch_i ? latch_val_i : value_q;
        cmp_d   = chg_next_i && (cnt_next_i >= {2'b00, value_d});
    end

    // Value and comparator registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            value_q <= PotAbsent;
            cmp_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            cmp_q   <= cmp_d;
        end
    end

    assign value_o = value_q;
    assign cmp_o   = cmp_q;

endmodule

// File: rtl/pot_sequencer.sv
// Discharge/charge sequencer emulating the two pot comparators of a paddle pair.
module pot_sequencer
    import pot_pkg::*;
#(
    parameter int unsigned DIS_TICKS = 256,
    parameter int unsigned CHG_TICKS = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic            enable,
    input  logic            restart,
    input  logic            pair_sel,
    input  logic [3:0][7:0] pd_in,
    input  logic [3:0]      pd_present,
    output logic [1:0]      pot_cmp,
    output logic [1:0][7:0] pot_value,
    output logic            sample_done,
    output logic [1:0]      phase
);

    localparam logic [CntWidth-1:0] DisLast = CntWidth'(DIS_TICKS - 1);
    localparam logic [CntWidth-1:0] ChgLast = CntWidth'(CHG_TICKS - 1);

    pot_state_e          state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                latch;
    logic                chg_next;
    logic [7:0]          sel_val0, sel_val1;

    // Next state: disable beats restart, restart beats tick-driven advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        latch   = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (restart) begin
            state_d = StDischarge;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ce) begin
                        state_d = StDischarge;
                        cnt_d   = '0;
                    end
                end
                StDischarge: begin
                    if (ce) begin
                        if (cnt_q == DisLast) begin
                            state_d = StCharge;
                            cnt_d   = '0;
                            latch   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StCharge: begin
                    if (ce) begin
                        if (cnt_q == ChgLast) begin
                            state_d = StDischarge;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and end-of-charge pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Paddle routing for the selected pair.
    always_comb begin
        sel_val0 = pick_pot(pd_in, pd_present, {pair_sel, 1'b0});
        sel_val1 = pick_pot(pd_in, pd_present, {pair_sel, 1'b1});
        chg_next = (state_d == StCharge);
    end

    pot_channel u_chan_x (
        .clk_i       (clk),
        .reset_i     (reset),
        .latch_i     (latch),
        .latch_val_i (sel_val0),
        .chg_next_i  (chg_next),
        .cnt_next_i  (cnt_d),
        .value_o     (pot_value[0]),
        .cmp_o       (pot_cmp[0])
    );

    pot_channel u_chan_y (
        .clk_i       (clk),
        .reset_i     (reset),
        .latch_i     (latch),
        .latch_val_i (sel_val1),
        .chg_next_i  (chg_next),
        .cnt_next_i  (cnt_d),
        .value_o     (pot_value[1]),
        .cmp_o       (pot_cmp[1])
    );

    assign sample_done = done_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_pot_sequencer.sv
// Self-checking bench for pot_sequencer against a period-time reference model.
module tb_pot_sequencer;

    localparam int DIS = 256;
    localparam int CHG = 256;

    logic            clk = 1'b0;
    logic            reset, ce, enable, restart, pair_sel;
    logic [3:0][7:0] pd_in;
    logic [3:0]      pd_present;
    logic [1:0]      pot_cmp;
    logic [1:0][7:0] pot_value;
    logic            sample_done;
    logic [1:0]      phase;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: ticks elapsed since the start of the current period.
    bit         m_idle;
    int         m_t;
    logic [7:0] m_val [2];
    bit         m_done;

    pot_sequencer #(.DIS_TICKS(DIS), .CHG_TICKS(CHG)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .enable      (enable),
        .restart     (restart),
        .pair_sel    (pair_sel),
        .pd_in       (pd_in),
        .pd_present  (pd_present),
        .pot_cmp     (pot_cmp),
        .pot_value   (pot_value),
        .sample_done (sample_done),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_phase();
        if (m_idle) return 2'd0;
        return (m_t < DIS) ? 2'd1 : 2'd2;
    endfunction

    function automatic int m_cnt();
        return (m_t < DIS) ? m_t : m_t - DIS;
    endfunction

    function automatic logic [20:0] exp_vec();
        logic [1:0] c;
        for (int i = 0; i < 2; i++) c[i] = (m_phase() == 2'd2) && (m_cnt() >= int'(m_val[i]));
        return {m_phase(), c, m_done, m_val[1], m_val[0]};
    endfunction

    function automatic logic [20:0] obs_vec();
        return {phase, pot_cmp, sample_done, pot_value};
    endfunction

    // Advance one clock and the model with the inputs present at that edge.
    task automatic step();
        int idx;
        @(posedge clk);
        m_done = 0;
        if (reset) begin
            m_idle = 1; m_t = 0; m_val[0] = 8'hFF; m_val[1] = 8'hFF;
        end else if (!enable) begin
            m_idle = 1; m_t = 0;
        end else if (restart) begin
            m_idle = 0; m_t = 0;
        end else if (ce) begin
            if (m_idle) begin
                m_idle = 0; m_t = 0;
            end else begin
                m_t++;
                if (m_t == DIS) begin
                    for (int i = 0; i < 2; i++) begin
                        idx = 2 * int'(pair_sel) + i;
                        m_val[i] = pd_present[idx] ? pd_in[idx] : 8'hFF;
                    end
                end
                if (m_t == DIS + CHG) begin
                    m_t = 0; m_done = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; ce = 0; restart = 0;
        step(); step();
        vectors++;
        if (obs_vec() !== {2'd0, 2'b00, 1'b0, 16'hFFFF}) begin
            miscompares++;
            $display("FAIL reset_state: got %h required %h", obs_vec(), {2'd0, 2'b00, 1'b0, 16'hFFFF});
        end
        reset = 0;
    endtask

    task automatic test_basic();
        int chg_idx = 0, rise0 = -1, rise1 = -1, last_done = -1, period = -1;
        logic [1:0] prev_ph = phase, prev_cmp = pot_cmp;
        enable = 1; ce = 1; pair_sel = 0; pd_present = 4'b0011;
        pd_in[0] = 8'h40; pd_in[1] = 8'hC0; pd_in[2] = 8'h11; pd_in[3] = 8'h22;
        for (int k = 0; k < 1200; k++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                if (miscompares <= 40) $display("FAIL basic cyc %0d: got %h required %h", k, obs_vec(), exp_vec());
            end
            if (phase == 2'd2) chg_idx = (prev_ph == 2'd2) ? chg_idx + 1 : 0;
            if (pot_cmp[0] && !prev_cmp[0] && rise0 < 0) rise0 = chg_idx;
            if (pot_cmp[1] && !prev_cmp[1] && rise1 < 0) rise1 = chg_idx;
            if (sample_done) begin
                if (last_done >= 0 && period < 0) period = k - last_done;
                last_done = k;
            end
            prev_ph = phase; prev_cmp = pot_cmp;
        end
        vectors++;
        if (rise0 !== 64) begin miscompares++; $display("FAIL basic_rise0: got %0d required 64", rise0); end
        vectors++;
        if (rise1 !== 192) begin miscompares++; $display("FAIL basic_rise1: got %0d required 192", rise1); end
        vectors++;
        if (period !== 512) begin miscompares++; $display("FAIL basic_period: got %0d required 512", period); end
    endtask

    task automatic test_absent();
        int chg_idx = 0, rise1 = -1;
        bit entered = 0, seen_entry = 0;
        logic [1:0] prev_ph = phase, prev_cmp = pot_cmp;
        pd_in[0] = 8'h00; pd_present = 4'b0001;
        for (int k = 0; k < 1100; k++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                if (miscompares <= 40) $display("FAIL absent cyc %0d: got %h required %h", k, obs_vec(), exp_vec());
            end
            if (phase == 2'd2) chg_idx = (prev_ph == 2'd2) ? chg_idx + 1 : 0;
            if (phase == 2'd2 && prev_ph != 2'd2 && !entered) begin
                entered = 1; seen_entry = 1;
                vectors++;
                if (pot_cmp[0] !== 1'b1 || pot_value[1] !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL absent_entry: got cmp0=%b val1=%h required cmp0=1 val1=ff", pot_cmp[0], pot_value[1]);
                end
            end
            if (entered && pot_cmp[1] && !prev_cmp[1] && rise1 < 0) rise1 = chg_idx;
            prev_ph = phase; prev_cmp = pot_cmp;
        end
        vectors++;
        if (!seen_entry || rise1 !== 255) begin
            miscompares++;
            $display("FAIL absent_rise1: got %0d required 255", rise1);
        end
    endtask

    task automatic test_pair_sel();
        bit reached;
        bit entered = 0;
        logic [1:0] prev_ph;
        for (int k = 0; k < 1100 && !(m_phase() == 2'd2 && m_cnt() == 50); k++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                if (miscompares <= 40) $display("FAIL pairsel_wait cyc %0d: got %h required %h", k, obs_vec(), exp_vec());
            end
        end
        reached = (m_phase() == 2'd2 && m_cnt() == 50);
        vectors++;
        if (!reached) begin miscompares++; $display("FAIL pairsel_timeout: got no CHARGE tick 50 required one"); end
        pair_sel = 1; pd_in[2] = 8'h10; pd_present = 4'b0101;
        prev_ph = phase;
        for (int k = 0; k < 800; k++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                if (miscompares <= 40) $display("FAIL pairsel cyc %0d: got %h required %h", k, obs_vec(), exp_vec());
            end
            if (!entered && phase == 2'd2 && prev_ph != 2'd2) begin
                entered = 1;
                vectors++;
                if (pot_value !== 16'hFF10) begin
                    miscompares++;
                    $display("FAIL pairsel_next: got %h required ff10", pot_value);
                end
            end else if (!entered && phase == 2'd2) begin
                vectors++;
                if (pot_value !== 16'hFF00) begin
                    miscompares++;
                    $display("FAIL pairsel_hold: got %h required ff00", pot_value);
                end
            end
            prev_ph = phase;
        end
    endtask

    task automatic test_restart_disable();
        for (int k = 0; k < 1100 && !(m_phase() == 2'd2 && m_cnt() == 100); k++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                if (miscompares <= 40) $display("FAIL restart_wait cyc %0d: got %h required %h", k, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (!(m_phase() == 2'd2 && m_cnt() == 100)) begin
            miscompares++; $display("FAIL restart_timeout: got no CHARGE tick 100 required one");
        end
        restart = 1; step(); restart = 0;
        vectors++;
        if ({phase, pot_cmp, sample_done} !== 5'b01_00_0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL restart_dis: got %h required %h", obs_vec(), exp_vec());
        end
        for (int k = 0; k < 50; k++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec() || sample_done !== 1'b0) begin
                miscompares++;
                if (miscompares <= 40) $display("FAIL restart_run cyc %0d: got %h required %h", k, obs_vec(), exp_vec());
            end
        end
        enable = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if ({phase, pot_cmp, sample_done} !== 5'b00_00_0 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL disable_idle cyc %0d: got %h required %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_slow_ce();
        int last_done = -1, period = -1, dones = 0;
        enable = 1;
        for (int k = 0; k < 5000; k++) begin
            ce = (k % 4 == 0);
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                if (miscompares <= 40) $display("FAIL slowce cyc %0d: got %h required %h", k, obs_vec(), exp_vec());
            end
            if (sample_done) begin
                dones++;
                if (last_done >= 0 && period < 0) period = k - last_done;
                last_done = k;
            end
        end
        vectors++;
        if (dones < 2 || period !== 2048) begin
            miscompares++;
            $display("FAIL slowce_period: got %0d (%0d pulses) required 2048", period, dones);
        end
        ce = 1;
    endtask

    task automatic test_reset_mid_charge();
        for (int k = 0; k < 1100 && !(m_phase() == 2'd2 && m_cnt() == 200); k++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                if (miscompares <= 40) $display("FAIL rstchg_wait cyc %0d: got %h required %h", k, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (!(m_phase() == 2'd2 && m_cnt() == 200)) begin
            miscompares++; $display("FAIL rstchg_timeout: got no CHARGE tick 200 required one");
        end
        reset = 1; step(); reset = 0;
        vectors++;
        if (obs_vec() !== {2'd0, 2'b00, 1'b0, 16'hFFFF}) begin
            miscompares++;
            $display("FAIL rstchg_state: got %h required %h", obs_vec(), {2'd0, 2'b00, 1'b0, 16'hFFFF});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20000; k++) begin
            ce      = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 599) != 0);
            restart = ($urandom_range(0, 799) == 0);
            reset   = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 99) == 0) pair_sel = $urandom_range(0, 1);
            if ($urandom_range(0, 49) == 0) pd_in = {$urandom, $urandom} & 32'hFFFF_FFFF;
            if ($urandom_range(0, 199) == 0) pd_present = 4'($urandom_range(0, 15));
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                if (miscompares <= 40) $display("FAIL random cyc %0d: got %h required %h", k, obs_vec(), exp_vec());
            end
        end
        reset = 0; restart = 0; enable = 1;
    endtask

    initial begin
        reset = 1; ce = 0; enable = 0; restart = 0; pair_sel = 0;
        pd_in = '0; pd_present = '0;
        m_idle = 1; m_t = 0; m_val[0] = 8'hFF; m_val[1] = 8'hFF; m_done = 0;
        test_reset();
        test_basic();
        test_absent();
        test_pair_sel();
        test_restart_disable();
        test_slow_ce();
        test_reset_mid_charge();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
